// File: rtl/wb2axi_bridge_if.sv
// Bus bundle between a Wishbone classic master and a single-beat AXI4 slave.
// "master" is the bridge's view (WB target, AXI initiator); "slave" is the surrounding system.
interface wb2axi_bridge_if #(
    parameter int unsigned ID_WIDTH = 1
);
    logic [29:0]         wb_adr;
    logic [31:0]         wb_dat;
    logic [3:0]          wb_sel;
    logic                wb_we;
    logic                wb_cyc;
    logic                wb_stb;
    logic [31:0]         wb_rdt;
    logic                wb_ack;
    logic                wb_err;

    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [63:0]         wdata;
    logic [7:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [63:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        input  wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb,
        output wb_rdt, wb_ack, wb_err,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output wb_adr, wb_dat, wb_sel, wb_we, wb_cyc, wb_stb,
        input  wb_rdt, wb_ack, wb_err,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/wb2axi_bridge.sv
// Wishbone classic (32-bit) to AXI4 (64-bit) single-beat bridge, one transaction in flight.
// AXI error responses terminate the Wishbone cycle with err instead of ack.
module wb2axi_bridge #(
    parameter int unsigned         ID_WIDTH = 1,
    parameter logic [ID_WIDTH-1:0] AXI_ID   = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wb2axi_bridge_if.master        bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WRITE = 3'd1;
    localparam logic [2:0] WRESP = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] RRESP = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [29:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rdt_q, rdt_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    // A channel counts as done once its valid is low or is being accepted this cycle.
    logic aw_done, w_done;
    assign aw_done = !awvalid_q || bus.awready;
    assign w_done  = !wvalid_q || bus.wready;

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        rdt_d     = rdt_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.wb_cyc && bus.wb_stb) begin
                    adr_d = bus.wb_adr;
                    if (bus.wb_we) begin
                        dat_d     = bus.wb_dat;
                        sel_d     = bus.wb_sel;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = READ;
                    end
                end
            end
            WRITE: begin
                if (bus.awready) awvalid_d = 1'b0;
                if (bus.wready)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (bus.bvalid) begin
                    bready_d = 1'b0;
                    ack_d    = (bus.bresp == 2'b00);
                    err_d    = (bus.bresp != 2'b00);
                    state_d  = DONE;
                end
            end
            READ: begin
                if (bus.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RRESP;
                end
            end
            RRESP: begin
                if (bus.rvalid) begin
                    rready_d = 1'b0;
                    rdt_d    = adr_q[0] ? bus.rdata[63:32] : bus.rdata[31:0];
                    ack_d    = (bus.rresp == 2'b00);
                    err_d    = (bus.rresp != 2'b00);
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            rdt_q     <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            rdt_q     <= rdt_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign bus.wb_rdt  = rdt_q;
    assign bus.wb_ack  = ack_q;
    assign bus.wb_err  = err_q;

    assign bus.awid    = AXI_ID;
    assign bus.awaddr  = {adr_q, 2'b00};
    assign bus.awlen   = 8'd0;
    assign bus.awsize  = 3'd2;
    assign bus.awburst = 2'b01;
    assign bus.awvalid = awvalid_q;

    // The 32-bit word is replicated on both halves; the strobes pick the live lane.
    assign bus.wdata   = {dat_q, dat_q};
    assign bus.wstrb   = adr_q[0] ? {sel_q, 4'h0} : {4'h0, sel_q};
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = bready_q;

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = {adr_q, 2'b00};
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = 3'd2;
    assign bus.arburst = 2'b01;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

    logic unused_ok;
    assign unused_ok = ^{bus.bid, bus.rid, bus.rlast};
endmodule
